// File: rtl/ltc2308_scan_sampler.sv
// rtl/ltc2308_scan_sampler.sv - LTC2308 multi-channel SPI scan controller holding the latest result per channel
// Per-channel averaging over 2^AVG_LOG2 frames is built when LTC2308_AVG_EN is defined.
module ltc2308_scan_sampler #(
    parameter int NUM_CH        = 8,
    parameter int SCK_DIV       = 2,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int AVG_LOG2      = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 run,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 adc_convst,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    input  logic                 adc_sdo,
    output logic [12*NUM_CH-1:0] result,
    output logic                 result_valid,
    output logic [2:0]           result_ch,
    output logic                 busy
);
    if (NUM_CH < 1 || NUM_CH > 8 || SCK_DIV < 1 || CONVST_CYCLES < 1 || CONV_CYCLES < 1 ||
        AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_check
        $error("ltc2308_scan_sampler: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_CONVST, S_CONV_WAIT, S_SHIFT, S_PUBLISH} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [11:0] shift_q;
    logic [5:0]  cfg_sh_q;
    logic [5:0]  cfg_word;
    logic [2:0]  cur_ch_q, tag_q, next_ch;
    logic        primed_q, advance;
    logic [7:0]  mask8;

    assign mask8    = 8'(ch_mask);
    assign cfg_word = {1'b1, cur_ch_q[0], cur_ch_q[2:1], 1'b1, 1'b0};

`ifdef LTC2308_AVG_EN
    localparam int REP   = 1 << AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int ACC_W = 12 + AVG_LOG2;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [CNT_W-1:0] acnt_q [NUM_CH];
    logic [CNT_W-1:0] rep_q;
    logic [ACC_W-1:0] acc_sum, acc_avg;

    assign acc_sum = acc_q[tag_q] + ACC_W'(shift_q);
    assign acc_avg = acc_sum >> AVG_LOG2;
`endif

    // Lowest enabled channel above 'from' (or equal when incl), wrapping to the lowest enabled one.
    function automatic logic [2:0] pick(input logic [2:0] from, input logic [7:0] m, input logic incl);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) r = 3'(i);
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && (i > int'(from) || (incl && i == int'(from)))) r = 3'(i);
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (run && |ch_mask) state_d = S_CONVST;
            S_CONVST:    if (cnt_q == 16'(CONVST_CYCLES - 1)) state_d = S_CONV_WAIT;
            S_CONV_WAIT: if (cnt_q == 16'(CONV_CYCLES - 1)) state_d = S_SHIFT;
            S_SHIFT:     if (cnt_q == 16'(SCK_DIV - 1) && adc_sck && bit_q == 4'd11) state_d = S_PUBLISH;
            S_PUBLISH:   state_d = (run && |ch_mask) ? S_CONVST : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        advance = 1'b1;
`ifdef LTC2308_AVG_EN
        advance = (rep_q == CNT_W'(REP - 1)) || !mask8[cur_ch_q];
`endif
        if (state_q == S_IDLE)
            next_ch = pick(cur_ch_q, mask8, 1'b1);
        else if (advance)
            next_ch = pick(cur_ch_q, mask8, 1'b0);
        else
            next_ch = cur_ch_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            cfg_sh_q     <= '0;
            cur_ch_q     <= '0;
            tag_q        <= '0;
            primed_q     <= 1'b0;
            adc_convst   <= 1'b0;
            adc_sck      <= 1'b0;
            adc_sdi      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            busy         <= 1'b0;
`ifdef LTC2308_AVG_EN
            rep_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                acnt_q[i] <= '0;
            end
`endif
        end else begin
            state_q      <= state_d;
            adc_convst   <= (state_d == S_CONVST);
            busy         <= (state_d != S_IDLE);
            result_valid <= 1'b0;
            cnt_q        <= (state_d != state_q) ? '0 : cnt_q + 16'd1;

            if (state_d == S_IDLE) primed_q <= 1'b0;

            // New frame: the config shifted last frame now tags this frame's data.
            if (state_d == S_CONVST && state_q != S_CONVST) begin
                tag_q    <= cur_ch_q;
                cur_ch_q <= next_ch;
`ifdef LTC2308_AVG_EN
                rep_q    <= (state_q == S_IDLE || advance) ? '0 : rep_q + CNT_W'(1);
`endif
            end

            if (state_q == S_CONV_WAIT && state_d == S_SHIFT) begin
                cfg_sh_q <= cfg_word;
                adc_sdi  <= cfg_word[5];
                bit_q    <= '0;
            end

            if (state_q == S_SHIFT && cnt_q == 16'(SCK_DIV - 1)) begin
                cnt_q <= '0;
                if (!adc_sck) begin
                    adc_sck <= 1'b1;
                    shift_q <= {shift_q[10:0], adc_sdo};
                end else begin
                    adc_sck  <= 1'b0;
                    bit_q    <= bit_q + 4'd1;
                    cfg_sh_q <= {cfg_sh_q[4:0], 1'b0};
                    adc_sdi  <= cfg_sh_q[4];
                end
            end

            if (state_q == S_SHIFT && state_d == S_PUBLISH) begin
                primed_q <= 1'b1;
`ifdef LTC2308_AVG_EN
                if (primed_q) begin
                    if (acnt_q[tag_q] == CNT_W'(REP - 1)) begin
                        result[12*int'(tag_q) +: 12] <= acc_avg[11:0];
                        result_valid  <= 1'b1;
                        result_ch     <= tag_q;
                        acc_q[tag_q]  <= '0;
                        acnt_q[tag_q] <= '0;
                    end else begin
                        acc_q[tag_q]  <= acc_sum;
                        acnt_q[tag_q] <= acnt_q[tag_q] + CNT_W'(1);
                    end
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!mask8[i]) begin
                        acc_q[i]  <= '0;
                        acnt_q[i] <= '0;
                    end
                end
`else
                if (primed_q) begin
                    result[12*int'(tag_q) +: 12] <= shift_q;
                    result_valid <= 1'b1;
                    result_ch    <= tag_q;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_ltc2308_scan_sampler.sv
// tb/tb_ltc2308_scan_sampler.sv - scoreboard bench for ltc2308_scan_sampler with an LTC2308 behavioural model
module tb_ltc2308_scan_sampler;
    localparam int NUM_CH = 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              run;
    logic [NUM_CH-1:0] ch_mask;
    logic              adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic [12*NUM_CH-1:0] result;
    logic              result_valid;
    logic [2:0]        result_ch;
    logic              busy;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] val;
    } sb_t;

    sb_t        sb_q[$];
    logic [5:0] cfg_q[$];
    int         checks = 0;
    int         failures = 0;

    ltc2308_scan_sampler #(
        .NUM_CH(NUM_CH), .SCK_DIV(1), .CONVST_CYCLES(2), .CONV_CYCLES(4), .AVG_LOG2(2)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .run(run), .ch_mask(ch_mask),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
        .result(result), .result_valid(result_valid), .result_ch(result_ch), .busy(busy)
    );

    always #10 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] res_of(input int ch);
        return result[12*ch +: 12];
    endfunction

    // ADC model: conversion uses the config word shifted in during the previous frame.
    logic [11:0] m_sr = '0;
    logic [5:0]  m_cfg = '0;
    int          m_bits = 0;
    logic        m_sck_prev = 1'b0, m_cv_prev = 1'b0;
    logic [11:0] m_seq [4];
    int          m_seq_idx = 0;
    logic        m_use_seq = 1'b0;

    assign adc_sdo = m_sr[11];

    always @(negedge clk_clk) begin
        logic [2:0]  ch;
        logic [11:0] val;
        if (!reset_reset_n) begin
            m_sr <= '0; m_cfg <= '0; m_bits <= 0; m_sck_prev <= 1'b0; m_cv_prev <= 1'b0;
        end else begin
            m_sck_prev <= adc_sck;
            m_cv_prev  <= adc_convst;
            if (adc_convst && !m_cv_prev) begin
                m_bits <= 0;
                if (m_bits >= 6) begin
                    ch = {m_cfg[3:2], m_cfg[4]};
                    check("cfg_fixed_bits", {29'd0, m_cfg[5], m_cfg[1:0]}, 32'b110);
                    if (cfg_q.size() != 0) check("cfg_word", {26'd0, m_cfg}, {26'd0, cfg_q.pop_front()});
                    val = 12'h100 * {9'd0, ch} + 12'h005;
                    if (m_use_seq && ch == 3'd1 && m_seq_idx < 4) begin
                        val = m_seq[m_seq_idx];
                        m_seq_idx <= m_seq_idx + 1;
                    end
                    m_sr <= val;
                end else begin
                    m_sr <= '0;
                end
            end else if (adc_sck && !m_sck_prev) begin
                if (m_bits < 6) m_cfg <= {m_cfg[4:0], adc_sdi};
                else check("sdi_idle_low", {31'd0, adc_sdi}, 32'd0);
                m_bits <= m_bits + 1;
            end else if (!adc_sck && m_sck_prev) begin
                m_sr <= {m_sr[10:0], 1'b0};
            end
        end
    end

    always @(negedge clk_clk) begin
        sb_t e;
        if (reset_reset_n && result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual_ch=%0d actual_value=0x%0h required=no_strobe",
                         result_ch, res_of(int'(result_ch)));
            end else begin
                e = sb_q.pop_front();
                check("strobe_ch", {29'd0, result_ch}, {29'd0, e.ch});
                check("strobe_value", {20'd0, res_of(int'(e.ch))}, {20'd0, e.val});
            end
        end
    end

    task automatic step();
        @(posedge clk_clk);
        #2;
    endtask

    task automatic expect_pub(input logic [2:0] ch, input logic [11:0] val);
        sb_t e;
        e.ch  = ch;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin step(); n++; end
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_sck(input string name);
        int n = 0;
        while (adc_sck !== 1'b1 && n < 200) begin step(); n++; end
        check(name, {31'd0, adc_sck}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin step(); n++; end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cv_cycles, busy_cycles;
        reset_reset_n = 1'b0;
        run           = 1'b0;
        ch_mask       = '0;
        repeat (3) step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_convst", {31'd0, adc_convst}, 32'd0);
        check("reset_sck", {31'd0, adc_sck}, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result_or", {31'd0, |result}, 32'd0);
        reset_reset_n = 1'b1;
        step();

`ifdef LTC2308_AVG_EN
        m_seq[0] = 12'd10; m_seq[1] = 12'd11; m_seq[2] = 12'd12; m_seq[3] = 12'd14;
        m_use_seq = 1'b1;
        expect_pub(3'd1, 12'd11);
        ch_mask = 8'h02;
        run     = 1'b1;
        wait_drain("avg_drain");
        run = 1'b0;
        wait_idle("avg_idle");
        check("avg_result_ch1", {20'd0, res_of(1)}, 32'd11);
`else
        // Scan 0,2: priming frame silent, then alternating publishes.
        cfg_q.push_back(6'b100010);
        cfg_q.push_back(6'b100110);
        expect_pub(3'd0, 12'h005);
        expect_pub(3'd2, 12'h205);
        expect_pub(3'd0, 12'h005);
        expect_pub(3'd2, 12'h205);
        ch_mask = 8'h05;
        run     = 1'b1;
        wait_drain("scan_drain");
        check("cfg_words_seen", cfg_q.size(), 0);

        // Mask switched during the frame whose channel was already chosen with the old mask.
        ch_mask = 8'h80;
        expect_pub(3'd0, 12'h005);
        expect_pub(3'd2, 12'h205);
        expect_pub(3'd7, 12'h705);
        expect_pub(3'd7, 12'h705);
        wait_drain("mask_change_drain");
        check("held_ch0", {20'd0, res_of(0)}, 32'h005);
        check("held_ch2", {20'd0, res_of(2)}, 32'h205);
        check("new_ch7", {20'd0, res_of(7)}, 32'h705);

        // run drops mid-SHIFT: current frame still publishes.
        wait_sck("stop_reach_shift");
        expect_pub(3'd7, 12'h705);
        run = 1'b0;
        wait_idle("stop_idle");
        check("stop_convst", {31'd0, adc_convst}, 32'd0);
        check("stop_sck", {31'd0, adc_sck}, 32'd0);
        check("stop_pending", sb_q.size(), 0);
        repeat (60) step();

        expect_pub(3'd0, 12'h005);
        expect_pub(3'd2, 12'h205);
        ch_mask = 8'h05;
        run     = 1'b1;
        wait_drain("restart_drain");
        expect_pub(3'd0, 12'h005);
        run = 1'b0;
        wait_idle("restart_idle");
        wait_drain("restart_tail");

        // Asynchronous reset in the middle of a data-carrying SHIFT.
        expect_pub(3'd2, 12'h205);
        run = 1'b1;
        wait_drain("pre_reset_drain");
        wait_sck("reset_reach_shift");
        reset_reset_n = 1'b0;
        #1;
        check("async_convst", {31'd0, adc_convst}, 32'd0);
        check("async_sck", {31'd0, adc_sck}, 32'd0);
        check("async_sdi", {31'd0, adc_sdi}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_valid", {31'd0, result_valid}, 32'd0);
        check("async_result_ch", {29'd0, result_ch}, 32'd0);
        check("async_result_or", {31'd0, |result}, 32'd0);
        run = 1'b0;
        repeat (3) step();
        reset_reset_n = 1'b1;
        repeat (5) step();
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_result_or", {31'd0, |result}, 32'd0);
`endif

        // Empty mask keeps the scanner idle even with run set.
        ch_mask     = '0;
        run         = 1'b1;
        cv_cycles   = 0;
        busy_cycles = 0;
        repeat (1000) begin
            step();
            if (adc_convst) cv_cycles++;
            if (busy) busy_cycles++;
        end
        check("empty_mask_convst", cv_cycles, 0);
        check("empty_mask_busy", busy_cycles, 0);
        run = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
